// File: rtl/demorgan_pkg.sv
// rtl/demorgan_pkg.sv - shared constants for the De Morgan sweep engine
package demorgan_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Identity positions; also the fail_mask bit order
   localparam int ID_NANDNB = 0;
   localparam int ID_NAORNB = 1;
   localparam int ID_ANORB  = 2;
   localparam int ID_ANANDB = 3;

   localparam int SAMPLE_LAT_MAX = 4;

endpackage

// File: rtl/demorgan_sweep_golden.sv
// rtl/demorgan_sweep_golden.sv - combinational reference for the four De Morgan identities
module demorgan_golden #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] nAandnB,
   output logic [WIDTH-1:0] nAornB,
   output logic [WIDTH-1:0] AnorB,
   output logic [WIDTH-1:0] AnandB
);

   assign nAandnB = ~a & ~b;
   assign nAornB  = ~a | ~b;
   assign AnorB   = ~(a | b);
   assign AnandB  = ~(a & b);

endmodule

// File: rtl/demorgan_sweep.sv
// rtl/demorgan_sweep.sv - exhaustive operand sweep with latency-aligned golden compare
// Optional first-failure capture ports: DEMORGAN_SWEEP_FIRST_FAIL_EN
module demorgan_sweep
   import demorgan_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int SAMPLE_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] dut_nAandnB,
   input  logic [WIDTH-1:0] dut_nAornB,
   input  logic [WIDTH-1:0] dut_AnorB,
   input  logic [WIDTH-1:0] dut_AnandB,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2*WIDTH:0] err_count
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
   ,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [3:0]       fail_mask
`endif
);

   localparam int CNT_W = $clog2(SAMPLE_LAT_MAX + 1);
   localparam logic [2*WIDTH:0]   ERR_ONE = 1;
   localparam logic [2*WIDTH-1:0] IDX_ONE = 1;
   localparam logic [CNT_W-1:0]   CNT_ONE = 1;

   logic [1:0]                state;
   logic [2*WIDTH-1:0]        idx;
   logic [CNT_W-1:0]          drain_cnt;
   logic [WIDTH-1:0]          g_nandnb, g_naornb, g_anorb, g_anandb;
   logic [3:0][WIDTH-1:0]     gold_now;
   logic [3:0][WIDTH-1:0]     dut_bus;
   logic [3:0][WIDTH-1:0]     gold_pipe [SAMPLE_LAT];
   logic [SAMPLE_LAT-1:0]     vld_pipe;
   logic [3:0]                diff;
   logic                      mismatch;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
   logic [2*WIDTH-1:0]        vec_pipe [SAMPLE_LAT];
`endif

   demorgan_golden #(.WIDTH(WIDTH)) u_golden (
      .a       (idx[2*WIDTH-1:WIDTH]),
      .b       (idx[WIDTH-1:0]),
      .nAandnB (g_nandnb),
      .nAornB  (g_naornb),
      .AnorB   (g_anorb),
      .AnandB  (g_anandb)
   );

   always_comb begin
      gold_now            = '0;
      gold_now[ID_NANDNB] = g_nandnb;
      gold_now[ID_NAORNB] = g_naornb;
      gold_now[ID_ANORB]  = g_anorb;
      gold_now[ID_ANANDB] = g_anandb;
      dut_bus             = '0;
      dut_bus[ID_NANDNB]  = dut_nAandnB;
      dut_bus[ID_NAORNB]  = dut_nAornB;
      dut_bus[ID_ANORB]   = dut_AnorB;
      dut_bus[ID_ANANDB]  = dut_AnandB;
      diff = '0;
      for (int i = 0; i < 4; i++) diff[i] = |(dut_bus[i] ^ gold_pipe[SAMPLE_LAT-1][i]);
      mismatch = vld_pipe[SAMPLE_LAT-1] & (|diff);
   end

   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         drain_cnt <= '0;
         A         <= '0;
         B         <= '0;
         busy      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         vld_pipe  <= '0;
         for (int j = 0; j < SAMPLE_LAT; j++) gold_pipe[j] <= '0;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
         for (int j = 0; j < SAMPLE_LAT; j++) vec_pipe[j] <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_mask  <= '0;
`endif
      end else begin
         // The golden delay line shifts every cycle; only launches in DRIVE are valid
         vld_pipe[0]  <= (state == ST_DRIVE);
         gold_pipe[0] <= gold_now;
         for (int j = 1; j < SAMPLE_LAT; j++) begin
            vld_pipe[j]  <= vld_pipe[j-1];
            gold_pipe[j] <= gold_pipe[j-1];
         end
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
         vec_pipe[0] <= idx;
         for (int j = 1; j < SAMPLE_LAT; j++) vec_pipe[j] <= vec_pipe[j-1];
         if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= vec_pipe[SAMPLE_LAT-1][2*WIDTH-1:WIDTH];
            fail_b     <= vec_pipe[SAMPLE_LAT-1][WIDTH-1:0];
            fail_mask  <= diff;
         end
`endif
         if (mismatch) err_count <= err_count + ERR_ONE;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_DRIVE;
                  idx       <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  vld_pipe  <= '0;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
                  fail_valid <= 1'b0;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  fail_mask  <= '0;
`endif
               end
            end
            ST_DRIVE: begin
               A    <= idx[2*WIDTH-1:WIDTH];
               B    <= idx[WIDTH-1:0];
               busy <= 1'b1;
               if (&idx) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end else begin
                  idx <= idx + IDX_ONE;
               end
            end
            ST_DRAIN: begin
               // One cycle beyond the latency so the last compare lands before pass is taken
               if (drain_cnt == CNT_W'(SAMPLE_LAT)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  pass  <= (err_count == '0);
               end else begin
                  drain_cnt <= drain_cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
               A     <= '0;
               B     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_demorgan_sweep.sv
// tb/tb_demorgan_sweep.sv - scoreboard bench over three sweep configurations
module tb_demorgan_sweep;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start;
   int   sel;
   int   mode_w1;
   int   mode_w2;

   int n_checks = 0;
   int n_pass   = 0;

   logic       start1, start2, start3;
   logic [0:0] A1, B1;
   logic [1:0] A2, B2, A3, B3;
   logic [0:0] d1_nn, d1_no, d1_nor, d1_nand;
   logic [1:0] d2_nn, d2_no, d2_nor, d2_nand;
   logic [1:0] d3_nn, d3_no, d3_nor, d3_nand;
   logic       busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
   logic [2:0] err1;
   logic [4:0] err2, err3;
   logic [3:0] p1 = '0, p2 = '0, q1 = '0, q2 = '0;
   logic [3:0] src2;

   assign start1 = start && (sel == 0);
   assign start2 = start && (sel == 1);
   assign start3 = start && (sel == 2);

`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
   logic       fv1, fv2, fv3;
   logic [0:0] fa1, fb1;
   logic [1:0] fa2, fb2, fa3, fb3;
   logic [3:0] fm1, fm2, fm3;
`endif

   demorgan_sweep #(.WIDTH(1), .SAMPLE_LAT(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1),
      .dut_nAandnB(d1_nn), .dut_nAornB(d1_no), .dut_AnorB(d1_nor), .dut_AnandB(d1_nand),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      , .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_mask(fm1)
`endif
   );

   demorgan_sweep #(.WIDTH(2), .SAMPLE_LAT(1)) u_w2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .A(A2), .B(B2),
      .dut_nAandnB(d2_nn), .dut_nAornB(d2_no), .dut_AnorB(d2_nor), .dut_AnandB(d2_nand),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      , .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_mask(fm2)
`endif
   );

   demorgan_sweep #(.WIDTH(2), .SAMPLE_LAT(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .A(A3), .B(B3),
      .dut_nAandnB(d3_nn), .dut_nAornB(d3_no), .dut_AnorB(d3_nor), .dut_AnandB(d3_nand),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      , .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_mask(fm3)
`endif
   );

   // Gate-level stand-ins for the device being swept, with selectable faults
   always_ff @(posedge clk) begin
      p1 <= {A2, B2};
      p2 <= p1;
      q1 <= {A3, B3};
      q2 <= q1;
   end

   always_comb begin
      d1_nn   = ~A1 & ~B1;
      d1_no   = ~A1 | ~B1;
      d1_nor  = (mode_w1 == 1) ? 1'b0 : ~(A1 | B1);
      d1_nand = ~(A1 & B1);
      src2    = (mode_w2 == 2) ? p2 : {A2, B2};
      d2_nn   = ~src2[3:2] & ~src2[1:0];
      d2_no   = ~src2[3:2] | ~src2[1:0];
      d2_nor  = ~(src2[3:2] | src2[1:0]);
      d2_nand = ~(src2[3:2] & src2[1:0]) ^ ((mode_w2 == 1) ? 2'b01 : 2'b00);
      d3_nn   = ~q2[3:2] & ~q2[1:0];
      d3_no   = ~q2[3:2] | ~q2[1:0];
      d3_nor  = ~(q2[3:2] | q2[1:0]);
      d3_nand = ~(q2[3:2] & q2[1:0]);
   end

   logic [1:0] ob_a, ob_b;
   logic       ob_busy, ob_done, ob_pass;
   logic [4:0] ob_err;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
   logic       ob_fv;
   logic [1:0] ob_fa, ob_fb;
   logic [3:0] ob_fm;
`endif

   always_comb begin
      ob_a = {1'b0, A1}; ob_b = {1'b0, B1};
      ob_busy = busy1; ob_done = done1; ob_pass = pass1; ob_err = {2'b00, err1};
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      ob_fv = fv1; ob_fa = {1'b0, fa1}; ob_fb = {1'b0, fb1}; ob_fm = fm1;
`endif
      if (sel == 1) begin
         ob_a = A2; ob_b = B2; ob_busy = busy2; ob_done = done2; ob_pass = pass2; ob_err = err2;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
         ob_fv = fv2; ob_fa = fa2; ob_fb = fb2; ob_fm = fm2;
`endif
      end else if (sel == 2) begin
         ob_a = A3; ob_b = B3; ob_busy = busy3; ob_done = done3; ob_pass = pass3; ob_err = err3;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
         ob_fv = fv3; ob_fa = fa3; ob_fb = fb3; ob_fm = fm3;
`endif
      end
   end

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
   } vec_t;

   vec_t sb[$];

   int         done_cyc, n_done, sb_bad, busy_bad;
   logic [4:0] rec_err;
   logic       rec_pass;
   logic [3:0] idle_ab;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
   logic       rec_fv;
   logic [1:0] rec_fa, rec_fb;
   logic [3:0] rec_fm;
`endif

   // Launches one sweep on the selected instance; must be entered away from a rising edge
   task automatic run_sweep(input int w, input int lat, input bit repulse);
      int   side;
      int   n;
      vec_t v;
      vec_t last;
      side = 1 << w;
      n    = side * side;
      for (int k = 0; k < n; k++) begin
         v.a = 2'(k / side);
         v.b = 2'(k % side);
         sb.push_back(v);
      end
      done_cyc = -1; n_done = 0; sb_bad = 0; busy_bad = 0; last = '0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 0; cyc <= n + lat + 2; cyc++) begin
         @(negedge clk);
         if (ob_busy !== ((cyc >= 1) && (cyc <= n + lat))) busy_bad++;
         if (ob_done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            rec_err  = ob_err;
            rec_pass = ob_pass;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
            rec_fv = ob_fv; rec_fa = ob_fa; rec_fb = ob_fb; rec_fm = ob_fm;
`endif
         end
         if (cyc >= 1 && cyc <= n) begin
            if (sb.size() == 0) sb_bad++;
            else begin
               v    = sb.pop_front();
               last = v;
               if ({ob_a, ob_b} !== {v.a, v.b}) sb_bad++;
            end
         end else if (cyc > n && cyc <= n + lat + 1) begin
            if ({ob_a, ob_b} !== {last.a, last.b}) sb_bad++;
         end
         start = repulse && (cyc == 3 || cyc == 5);
      end
      sb_bad += sb.size();
      sb.delete();
      idle_ab = {ob_a, ob_b};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mode_w1 = 0; mode_w2 = 0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if ({ob_a, ob_b, ob_busy, ob_done, ob_pass, ob_err} !== 14'd0)
            $display("FAIL reset_state inst %0d got %h want 0", s, {ob_a, ob_b, ob_busy, ob_done, ob_pass, ob_err});
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel = 0;
      @(negedge clk);
   endtask

   task automatic test_clean_w1();
      sel = 0; mode_w1 = 0;
      run_sweep(1, 1, 1'b0);
      n_checks++; if (sb_bad !== 0) $display("FAIL clean_w1 vectors got %0d bad want 0", sb_bad); else n_pass++;
      n_checks++; if (busy_bad !== 0) $display("FAIL clean_w1 busy got %0d bad want 0", busy_bad); else n_pass++;
      n_checks++; if (n_done !== 1) $display("FAIL clean_w1 done_count got %0d want 1", n_done); else n_pass++;
      n_checks++; if (done_cyc !== 6) $display("FAIL clean_w1 done_cycle got %0d want 6", done_cyc); else n_pass++;
      n_checks++; if (rec_err !== 5'd0) $display("FAIL clean_w1 err_count got %0d want 0", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b1) $display("FAIL clean_w1 pass got %b want 1", rec_pass); else n_pass++;
      n_checks++; if (idle_ab !== 4'd0) $display("FAIL clean_w1 idle_ab got %h want 0", idle_ab); else n_pass++;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      n_checks++; if (rec_fv !== 1'b0) $display("FAIL clean_w1 fail_valid got %b want 0", rec_fv); else n_pass++;
`endif
   endtask

   task automatic test_stuck_w1();
      sel = 0; mode_w1 = 1;
      run_sweep(1, 1, 1'b0);
      mode_w1 = 0;
      n_checks++; if (rec_err !== 5'd1) $display("FAIL stuck_w1 err_count got %0d want 1", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b0) $display("FAIL stuck_w1 pass got %b want 0", rec_pass); else n_pass++;
      n_checks++; if (sb_bad !== 0) $display("FAIL stuck_w1 vectors got %0d bad want 0", sb_bad); else n_pass++;
      n_checks++; if (done_cyc !== 6) $display("FAIL stuck_w1 done_cycle got %0d want 6", done_cyc); else n_pass++;
`ifdef DEMORGAN_SWEEP_FIRST_FAIL_EN
      n_checks++; if (rec_fv !== 1'b1) $display("FAIL stuck_w1 fail_valid got %b want 1", rec_fv); else n_pass++;
      n_checks++; if ({rec_fa, rec_fb} !== 4'd0) $display("FAIL stuck_w1 fail_ab got %h want 0", {rec_fa, rec_fb}); else n_pass++;
      n_checks++; if (rec_fm !== 4'b0100) $display("FAIL stuck_w1 fail_mask got %b want 0100", rec_fm); else n_pass++;
`endif
   endtask

   task automatic test_inverted_w2();
      sel = 1; mode_w2 = 1;
      run_sweep(2, 1, 1'b0);
      mode_w2 = 0;
      n_checks++; if (rec_err !== 5'd16) $display("FAIL inverted_w2 err_count got %0d want 16", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b0) $display("FAIL inverted_w2 pass got %b want 0", rec_pass); else n_pass++;
      n_checks++; if (done_cyc !== 18) $display("FAIL inverted_w2 done_cycle got %0d want 18", done_cyc); else n_pass++;
      n_checks++; if (sb_bad !== 0) $display("FAIL inverted_w2 vectors got %0d bad want 0", sb_bad); else n_pass++;
      n_checks++; if (busy_bad !== 0) $display("FAIL inverted_w2 busy got %0d bad want 0", busy_bad); else n_pass++;
   endtask

   task automatic test_latency();
      sel = 2;
      run_sweep(2, 3, 1'b0);
      n_checks++; if (rec_err !== 5'd0) $display("FAIL latency3 err_count got %0d want 0", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b1) $display("FAIL latency3 pass got %b want 1", rec_pass); else n_pass++;
      n_checks++; if (done_cyc !== 20) $display("FAIL latency3 done_cycle got %0d want 20", done_cyc); else n_pass++;
      n_checks++; if (busy_bad !== 0) $display("FAIL latency3 busy got %0d bad want 0", busy_bad); else n_pass++;
      n_checks++; if (sb_bad !== 0) $display("FAIL latency3 vectors got %0d bad want 0", sb_bad); else n_pass++;
      sel = 1; mode_w2 = 2;
      run_sweep(2, 1, 1'b0);
      mode_w2 = 0;
      n_checks++; if (rec_err === 5'd0 || $isunknown(rec_err)) $display("FAIL latency1 err_count got %0d want nonzero", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b0) $display("FAIL latency1 pass got %b want 0", rec_pass); else n_pass++;
   endtask

   task automatic test_start_ignored();
      sel = 0; mode_w1 = 0;
      run_sweep(1, 1, 1'b1);
      n_checks++; if (n_done !== 1) $display("FAIL start_ignored done_count got %0d want 1", n_done); else n_pass++;
      n_checks++; if (done_cyc !== 6) $display("FAIL start_ignored done_cycle got %0d want 6", done_cyc); else n_pass++;
      n_checks++; if (busy_bad !== 0) $display("FAIL start_ignored busy got %0d bad want 0", busy_bad); else n_pass++;
      n_checks++; if (sb_bad !== 0) $display("FAIL start_ignored vectors got %0d bad want 0", sb_bad); else n_pass++;
      n_checks++; if (rec_err !== 5'd0) $display("FAIL start_ignored err_count got %0d want 0", rec_err); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int seen_done;
      int seen_busy;
      sel = 0; mode_w1 = 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (ob_busy !== 1'b1) $display("FAIL abort busy_before got %b want 1", ob_busy); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ob_a, ob_b, ob_busy, ob_done, ob_pass, ob_err} !== 14'd0)
         $display("FAIL abort outputs got %h want 0", {ob_a, ob_b, ob_busy, ob_done, ob_pass, ob_err});
      else n_pass++;
      seen_done = 0; seen_busy = 0;
      repeat (3) begin
         @(negedge clk);
         if (ob_done !== 1'b0) seen_done++;
         if (ob_busy !== 1'b0) seen_busy++;
      end
      rst_n = 1'b1; mode_w1 = 0;
      repeat (4) begin
         @(negedge clk);
         if (ob_done !== 1'b0) seen_done++;
         if (ob_busy !== 1'b0) seen_busy++;
      end
      n_checks++; if (seen_done !== 0) $display("FAIL abort no_done got %0d want 0", seen_done); else n_pass++;
      n_checks++; if (seen_busy !== 0) $display("FAIL abort no_busy got %0d want 0", seen_busy); else n_pass++;
      run_sweep(1, 1, 1'b0);
      n_checks++; if (rec_err !== 5'd0) $display("FAIL abort_resweep err_count got %0d want 0", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b1) $display("FAIL abort_resweep pass got %b want 1", rec_pass); else n_pass++;
      n_checks++; if (done_cyc !== 6) $display("FAIL abort_resweep done_cycle got %0d want 6", done_cyc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      sel = 0; mode_w1 = 1;
      run_sweep(1, 1, 1'b0);
      n_checks++; if (rec_err !== 5'd1) $display("FAIL b2b_first err_count got %0d want 1", rec_err); else n_pass++;
      mode_w1 = 0;
      run_sweep(1, 1, 1'b0);
      n_checks++; if (done_cyc !== 6) $display("FAIL b2b_second done_cycle got %0d want 6", done_cyc); else n_pass++;
      n_checks++; if (rec_err !== 5'd0) $display("FAIL b2b_second err_count got %0d want 0", rec_err); else n_pass++;
      n_checks++; if (rec_pass !== 1'b1) $display("FAIL b2b_second pass got %b want 1", rec_pass); else n_pass++;
      n_checks++; if (sb_bad !== 0) $display("FAIL b2b_second vectors got %0d bad want 0", sb_bad); else n_pass++;
   endtask

   initial begin
      sel = 0;
      test_reset();
      test_clean_w1();
      test_stuck_w1();
      test_inverted_w2();
      test_latency();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
